// File: rtl/dac5311_pkg.sv
// Shared definitions for the DAC5311 serial write path (transmitter and
// loopback receiver): frame size, field positions and the receiver states.
package dac5311_pkg;

    localparam int FRAME_BITS_DEF = 16;
    localparam int DATA_W         = 16;
    localparam int CNT_W          = 5;

    // Field positions inside a 16-bit DAC5311 frame
    localparam int PD_MSB   = 15;
    localparam int PD_LSB   = 14;
    localparam int CODE_MSB = 13;
    localparam int CODE_LSB = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    // Power-down mode field of a frame
    function automatic logic [PD_MSB-PD_LSB:0] frame_pd(input logic [DATA_W-1:0] frame);
        return frame[PD_MSB:PD_LSB];
    endfunction

    // 8-bit DAC code field of a frame
    function automatic logic [CODE_MSB-CODE_LSB:0] frame_code(input logic [DATA_W-1:0] frame);
        return frame[CODE_MSB:CODE_LSB];
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer with registered edge detection. The synchronized
// level (dout) is delayed by the same extra register that feeds the edge
// compare, so a data line run through another instance lines up with the
// edge pulses of this one.
module sync_edge_detect #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_r;
    logic              prev_r;
    logic              rise_r;
    logic              fall_r;

    // Synchronizer chain, one-deep history register and registered edge flags
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {STAGES{RESET_VAL}};
            prev_r <= RESET_VAL;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], din};
            prev_r <= sync_r[STAGES-1];
            rise_r <= ~prev_r & sync_r[STAGES-1];
            fall_r <= prev_r & ~sync_r[STAGES-1];
        end
    end

    assign dout = prev_r;
    assign rise = rise_r;
    assign fall = fall_r;

endmodule

// File: rtl/dac5311_frame_receiver.sv
// Loopback model of the DAC5311 serial input: oversamples sync_n/sclk/sdin on
// clk, shifts in one 16-bit frame per sync_n low window and decodes it into
// power-down mode and DAC code.
module dac5311_frame_receiver
    import dac5311_pkg::*;
#(
    parameter int FRAME_BITS  = FRAME_BITS_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sync_n,
    input  logic              sclk,
    input  logic              sdin,
    output logic [DATA_W-1:0] rx_data,
    output logic [1:0]        pd_mode,
    output logic [7:0]        dac_code,
    output logic              rx_valid,
    output logic              frame_err,
    output logic              busy
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS);

    logic sync_rise_s;
    logic sync_fall_s;
    logic sync_level_unused_s;
    logic sclk_fall_s;
    logic sclk_rise_unused_s;
    logic sclk_level_unused_s;
    logic sdin_s;
    logic sdin_rise_unused_s;
    logic sdin_fall_unused_s;

    state_t            state_r;
    state_t            state_next_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_next_s;
    logic [CNT_W-1:0]  cnt_inc_s;
    // Only 15 bits need holding: the 16th bit is taken straight from sdin
    // when the frame completes.
    logic [DATA_W-2:0] shift_r;
    logic [DATA_W-2:0] shift_next_s;
    logic [DATA_W-1:0] rx_data_r;
    logic [DATA_W-1:0] rx_data_next_s;
    logic              rx_valid_r;
    logic              rx_valid_next_s;
    logic              frame_err_r;
    logic              frame_err_next_s;
    logic              busy_r;

    sync_edge_detect #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync_n_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (sync_n),
        .dout (sync_level_unused_s),
        .rise (sync_rise_s),
        .fall (sync_fall_s)
    );

    sync_edge_detect #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sclk_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (sclk),
        .dout (sclk_level_unused_s),
        .rise (sclk_rise_unused_s),
        .fall (sclk_fall_s)
    );

    sync_edge_detect #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_sdin_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (sdin),
        .dout (sdin_s),
        .rise (sdin_rise_unused_s),
        .fall (sdin_fall_unused_s)
    );

    assign cnt_inc_s = cnt_r + 5'd1;

    // Frame FSM: next state, shift/count update and result pulses
    always_comb begin
        state_next_s     = state_r;
        cnt_next_s       = cnt_r;
        shift_next_s     = shift_r;
        rx_data_next_s   = rx_data_r;
        rx_valid_next_s  = 1'b0;
        frame_err_next_s = 1'b0;
        case (state_r)
            IDLE: begin
                // sclk edges are ignored until the frame is opened
                cnt_next_s = {CNT_W{1'b0}};
                if (sync_fall_s) begin
                    state_next_s = SHIFT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                if (sclk_fall_s) begin
                    cnt_next_s   = cnt_inc_s;
                    shift_next_s = {shift_r[DATA_W-3:0], sdin_s};
                    if (cnt_inc_s == LAST_CNT) begin
                        // A full frame wins over a coincident sync_n release
                        rx_data_next_s  = {shift_r, sdin_s};
                        rx_valid_next_s = 1'b1;
                        if (sync_rise_s) begin
                            state_next_s = IDLE;
                        end else begin
                            state_next_s = DONE;
                        end
                    end else if (sync_rise_s) begin
                        frame_err_next_s = 1'b1;
                        state_next_s     = IDLE;
                    end else begin
                        state_next_s = SHIFT;
                    end
                end else if (sync_rise_s) begin
                    // Short or empty frame
                    frame_err_next_s = 1'b1;
                    state_next_s     = IDLE;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            DONE: begin
                // Extra sclk edges after a complete frame are ignored
                if (sync_rise_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            shift_r     <= {(DATA_W-1){1'b0}};
            rx_data_r   <= {DATA_W{1'b0}};
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            cnt_r       <= cnt_next_s;
            shift_r     <= shift_next_s;
            rx_data_r   <= rx_data_next_s;
            rx_valid_r  <= rx_valid_next_s;
            frame_err_r <= frame_err_next_s;
            busy_r      <= (state_next_s != IDLE);
        end
    end

    assign rx_data   = rx_data_r;
    assign pd_mode   = frame_pd(rx_data_r);
    assign dac_code  = frame_code(rx_data_r);
    assign rx_valid  = rx_valid_r;
    assign frame_err = frame_err_r;
    assign busy      = busy_r;

endmodule
